regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single register-file write port between two writeback requesters: ALU (port A) and load/store unit (port B). Each requester uses a valid/ready handshake. The block arbitrates between them, registers the winning write onto the register-file write port, and keeps a 32-entry busy scoreboard of destination registers with writes still outstanding. It sits between the execute/memory stages and the register file, and feeds `busy` to the issue/hazard logic.

## Interface
- `XLEN`, 32, data width of write data
- `NREG`, 32, number of architectural registers; index width is clog2(NREG) = 5
---
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `a_valid`  in  1  ALU write request
- `a_rd`  in  5  ALU destination register
- `a_data`  in  XLEN  ALU write data
- `a_ready`  out  1  ALU request accepted this cycle
- `b_valid`  in  1  LSU write request
- `b_rd`  in  5  LSU destination register
- `b_data`  in  XLEN  LSU write data
- `b_ready`  out  1  LSU request accepted this cycle
- `iss_valid`  in  1  an instruction with a destination register is issued
- `iss_rd`  in  5  destination register of the issued instruction
- `wenable`  out  1  register-file write enable
- `rd`  out  5  register-file write address
- `wdata`  out  XLEN  register-file write data
- `busy`  out  NREG  bit r = 1 while register r has a pending write

## Operation
- Handshake: a transfer happens when `x_valid && x_ready`. `a_ready` and `b_ready` are combinational from the valids and the arbitration state. At most one of them is high per cycle.
- Requesters hold `x_valid`, `x_rd` and `x_data` stable until the transfer completes. A request is never dropped.
- One valid requester: it is granted.
- Both valid: the grant goes to the port not granted most recently (round-robin pointer `last`).
  - `last` updates only on a transfer.
  - `last` resets to B, so A wins the first tie.
- Output register: a transfer in cycle N loads `rd` and `wdata`. `wenable` is high in cycle N+1 only.
  - If the accepted `rd` is 0, the transfer completes but `wenable` stays 0 in N+1. x0 is never written.
- With no transfer, `wenable` = 0. `rd` and `wdata` hold their previous values.
- Scoreboard:
  - `busy[r]` is set at the edge ending a cycle with `iss_valid && iss_rd == r && r != 0`.
  - `busy[r]` is cleared at the edge ending a cycle with `wenable && rd == r`.
  - If set and clear hit the same register in the same cycle, set wins (a newer writer is in flight).
  - `busy[0]` is constant 0.

## Timing
- Reset values: `wenable` = 0, `rd` = 0, `wdata` = 0, `busy` = 0, `last` = B.
- `a_ready` and `b_ready` are 0 whenever their own valid is 0, including during reset.
- Latency from transfer to the register-file write is 1 cycle. The register file captures the data at the end of cycle N+1. `busy[r]` falls in the same cycle that the written value becomes readable, at N+2.
- Throughput: one write per cycle. Back-to-back transfers from the same or alternating ports are supported with no bubble.
- Reset asserted mid-operation: all state clears immediately. A transfer accepted in the previous cycle is discarded and no write occurs.

## Configuration
- `WB_ARB_RR_EN` defined: round-robin arbitration as described above.
- `WB_ARB_RR_EN` undefined: fixed priority, where B (LSU) always wins a tie. The `last` register is not implemented. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 with `a_valid` = 1. Expect `busy` = 0, `wenable` = 0, `a_ready` = 0. Release reset: `a_ready` = 1 in the first cycle.
- Single write: `a_valid`, `a_rd` = 5, `a_data` = 0xDEADBEEF in cycle N. Expect `a_ready` = 1 in N, and `wenable` = 1, `rd` = 5, `wdata` = 0xDEADBEEF in N+1 only.
- Contention: A and B both valid for 4 consecutive cycles, each with new data after every transfer.
  - With RR: grants are A, B, A, B.
  - Without RR: B, B, B, B, with A stalled and `a_ready` = 0.
- x0 write: `b_valid`, `b_rd` = 0, `b_data` = 0x1234. Expect `b_ready` = 1, `wenable` = 0 in the next cycle, and `busy[0]` = 0 throughout.
- Scoreboard: `iss_valid`, `iss_rd` = 7 → `busy[7]` = 1. Then an A write to rd 7 → `busy[7]` = 0 the cycle after `wenable`. Repeat with `iss_rd` = 7 asserted in the `wenable` cycle → `busy[7]` stays 1.
- Reset mid-operation: transfer to rd 9 in cycle N, then `rst_n` = 0 during N+1. Expect `wenable` to drop immediately, no write to 9, and `busy` = 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters, the issue stage and the register-file write port.
// Master drives the requests and the issue info; slave (the arbiter) returns readies, the write port and busy.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int RW = $clog2(NREG);

    logic            a_valid;
    logic [RW-1:0]   a_rd;
    logic [XLEN-1:0] a_data;
    logic            a_ready;

    logic            b_valid;
    logic [RW-1:0]   b_rd;
    logic [XLEN-1:0] b_data;
    logic            b_ready;

    logic            iss_valid;
    logic [RW-1:0]   iss_rd;

    logic            wenable;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] wdata;
    logic [NREG-1:0] busy;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
        input  a_ready, b_ready, wenable, rd, wdata, busy
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
        output a_ready, b_ready, wenable, rd, wdata, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and LSU (B) writebacks onto one register-file write port; tracks pending writes in a busy scoreboard.
// Latency: transfer in cycle N -> wenable in N+1; busy clears at the end of the wenable cycle. WB_ARB_RR_EN selects round-robin, else B wins ties.
// Backpressure: the losing requester sees ready=0 and must hold its request; readies are 0 while its valid is low or reset is asserted.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int RW = $clog2(NREG);

    logic            grant_a;
    logic            grant_b;
    logic            xfer;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            wen_q;
    logic [RW-1:0]   rd_q;
    logic [XLEN-1:0] wdata_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

`ifdef WB_ARB_RR_EN
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_e;

    last_e last_q;
    last_e last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_B;
        end else begin
            last_q <= last_d;
        end
    end

    // Tie goes to the port that did not win the last transfer.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        last_d  = last_q;
        if (rst_n) begin
            if (bus.a_valid && (!bus.b_valid || last_q == LAST_B)) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
        if (grant_a) begin
            last_d = LAST_A;
        end else if (grant_b) begin
            last_d = LAST_B;
        end
    end
`else
    always_comb begin
        grant_b = rst_n && bus.b_valid;
        grant_a = rst_n && bus.a_valid && !bus.b_valid;
    end
`endif

    assign xfer     = grant_a || grant_b;
    assign sel_rd   = grant_a ? bus.a_rd   : bus.b_rd;
    assign sel_data = grant_a ? bus.a_data : bus.b_data;

    // rd/wdata load on any transfer, but a write to x0 never raises wenable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= xfer && (sel_rd != '0);
            if (xfer) begin
                rd_q    <= sel_rd;
                wdata_q <= sel_data;
            end
        end
    end

    // A same-cycle issue to the register being written wins: a newer writer is in flight.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (bus.iss_valid && bus.iss_rd == RW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (wen_q && rd_q == RW'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;
    assign bus.wenable = wen_q;
    assign bus.rd      = rd_q;
    assign bus.wdata   = wdata_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter; follows WB_ARB_RR_EN for the contention vectors.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdat;
        logic        iv;
        logic [4:0]  ird;
        logic        ea;
        logic        eb;
        logic        ewen;
        logic [4:0]  erd;
        logic [31:0] ewd;
        logic [31:0] ebusy;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic vec_t mkv(
        input logic av, input logic [4:0] ard, input logic [31:0] adat,
        input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
        input logic iv, input logic [4:0] ird,
        input logic ea, input logic eb, input logic ewen,
        input logic [4:0] erd, input logic [31:0] ewd, input logic [31:0] ebusy);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.bv = bv; v.brd = brd; v.bdat = bdat;
        v.iv = iv; v.ird = ird;
        v.ea = ea; v.eb = eb; v.ewen = ewen;
        v.erd = erd; v.ewd = ewd; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
    endtask

    localparam logic [31:0] B7 = 32'h0000_0080;
    localparam logic [31:0] B9 = 32'h0000_0200;

    initial begin
        //            av ard   adat          bv brd   bdat          iv ird   ea eb wen erd   ewd           busy
        vt[0]  = mkv(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 1, 5'd5, 32'hDEADBEEF, 32'h0);
        vt[1]  = mkv(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       0, 5'd0, 0, 0, 0, 5'd5, 32'hDEADBEEF, 32'h0);
        vt[2]  = mkv(0, 5'd0, 32'h0,        1, 5'd0, 32'h1234,    0, 5'd0, 0, 1, 0, 5'd0, 32'h1234,     32'h0);
        vt[3]  = mkv(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       1, 5'd7, 0, 0, 0, 5'd0, 32'h1234,     B7);
        vt[4]  = mkv(1, 5'd7, 32'h77,       0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 1, 5'd7, 32'h77,       B7);
        vt[5]  = mkv(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       0, 5'd0, 0, 0, 0, 5'd7, 32'h77,       32'h0);
        vt[6]  = mkv(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       1, 5'd7, 0, 0, 0, 5'd7, 32'h77,       B7);
        vt[7]  = mkv(1, 5'd7, 32'h88,       0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 1, 5'd7, 32'h88,       B7);
        vt[8]  = mkv(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       1, 5'd7, 0, 0, 0, 5'd7, 32'h88,       B7);
        vt[9]  = mkv(1, 5'd7, 32'h99,       0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 1, 5'd7, 32'h99,       B7);
        vt[10] = mkv(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       0, 5'd0, 0, 0, 0, 5'd7, 32'h99,       32'h0);
        vt[11] = mkv(0, 5'd0, 32'h0,        1, 5'd3, 32'h33,      0, 5'd0, 0, 1, 1, 5'd3, 32'h33,       32'h0);
`ifdef WB_ARB_RR_EN
        vt[12] = mkv(1, 5'd10, 32'hA0,      1, 5'd11, 32'hB0,     0, 5'd0, 1, 0, 1, 5'd10, 32'hA0,      32'h0);
        vt[13] = mkv(1, 5'd10, 32'hA1,      1, 5'd11, 32'hB0,     0, 5'd0, 0, 1, 1, 5'd11, 32'hB0,      32'h0);
        vt[14] = mkv(1, 5'd10, 32'hA1,      1, 5'd11, 32'hB1,     0, 5'd0, 1, 0, 1, 5'd10, 32'hA1,      32'h0);
        vt[15] = mkv(1, 5'd10, 32'hA2,      1, 5'd11, 32'hB1,     0, 5'd0, 0, 1, 1, 5'd11, 32'hB1,      32'h0);
        vt[16] = mkv(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       0, 5'd0, 0, 0, 0, 5'd11, 32'hB1,      32'h0);
`else
        vt[12] = mkv(1, 5'd10, 32'hA0,      1, 5'd11, 32'hB0,     0, 5'd0, 0, 1, 1, 5'd11, 32'hB0,      32'h0);
        vt[13] = mkv(1, 5'd10, 32'hA0,      1, 5'd11, 32'hB1,     0, 5'd0, 0, 1, 1, 5'd11, 32'hB1,      32'h0);
        vt[14] = mkv(1, 5'd10, 32'hA0,      1, 5'd11, 32'hB2,     0, 5'd0, 0, 1, 1, 5'd11, 32'hB2,      32'h0);
        vt[15] = mkv(1, 5'd10, 32'hA0,      1, 5'd11, 32'hB3,     0, 5'd0, 0, 1, 1, 5'd11, 32'hB3,      32'h0);
        vt[16] = mkv(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       0, 5'd0, 0, 0, 0, 5'd11, 32'hB3,      32'h0);
`endif

        // Reset held with A requesting: nothing may be accepted.
        rst_n = 1'b0;
        drive_idle();
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd1;
        bus.b_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", {63'd0, bus.a_ready}, 64'd0);
        chk("rst_b_ready", {63'd0, bus.b_ready}, 64'd0);
        chk("rst_wenable", {63'd0, bus.wenable}, 64'd0);
        chk("rst_rd",      {59'd0, bus.rd},      64'd0);
        chk("rst_wdata",   {32'd0, bus.wdata},   64'd0);
        chk("rst_busy",    {32'd0, bus.busy},    64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector 0 is the first cycle out of reset.
        for (int i = 0; i < NV; i++) begin
            bus.a_valid = vt[i].av; bus.a_rd = vt[i].ard; bus.a_data = vt[i].adat;
            bus.b_valid = vt[i].bv; bus.b_rd = vt[i].brd; bus.b_data = vt[i].bdat;
            bus.iss_valid = vt[i].iv; bus.iss_rd = vt[i].ird;
            @(negedge clk);
            chk($sformatf("v%0d_a_ready", i), {63'd0, bus.a_ready}, {63'd0, vt[i].ea});
            chk($sformatf("v%0d_b_ready", i), {63'd0, bus.b_ready}, {63'd0, vt[i].eb});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wenable", i), {63'd0, bus.wenable}, {63'd0, vt[i].ewen});
            chk($sformatf("v%0d_rd", i),      {59'd0, bus.rd},      {59'd0, vt[i].erd});
            chk($sformatf("v%0d_wdata", i),   {32'd0, bus.wdata},   {32'd0, vt[i].ewd});
            chk($sformatf("v%0d_busy", i),    {32'd0, bus.busy},    {32'd0, vt[i].ebusy});
        end

        // Reset during the wenable cycle: the pending write to x9 is lost.
        drive_idle();
        bus.a_valid = 1'b1; bus.a_rd = 5'd9; bus.a_data = 32'h0000_0999;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        @(posedge clk);
        #1;
        chk("mid_wen_before", {63'd0, bus.wenable}, 64'd1);
        chk("mid_busy_before", {32'd0, bus.busy}, {32'd0, B9});
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_wen_drop", {63'd0, bus.wenable}, 64'd0);
        chk("mid_rd_clear", {59'd0, bus.rd}, 64'd0);
        chk("mid_busy_clear", {32'd0, bus.busy}, 64'd0);
        bus.b_valid = 1'b1;
        #1;
        chk("mid_b_ready_in_rst", {63'd0, bus.b_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("mid_wen_after", {63'd0, bus.wenable}, 64'd0);
        drive_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", {32'd0, bus.busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
